// File: rtl/noc_apb_ni_if.sv
// APB bus bundle used on both local sides of noc_apb_ni.
//   master modport : drives psel/penable/pwrite/paddr/pwdata, receives pready/prdata/pslverr
//   slave modport  : receives the request signals, drives pready/prdata/pslverr
interface noc_apb_ni_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/noc_apb_ni.sv
// Mesh network interface bridging one router port and two local APB buses.
//   i_clk, i_srst_n : clock, synchronous active-low reset
//   ini_apb         : APB slave side; local initiator transfers become request packets
//                     (paddr[31:28]=dstX, [27:24]=dstY, [23:0]=remote offset)
//   tgt_apb         : APB master side; incoming requests are replayed on the local peripheral
//   o_niToRouter    : registered packet to router, all zero when idle
//   i_routerToNi    : packet from router
//   o_dropCount     : saturating count of discarded packets
// Packet: [83]valid [82]resp [81]write [80]err [79:76]dstX [75:72]dstY [71:68]srcX
//         [67:64]srcY [63:32]addr [31:0]data
package pa_noc;
  localparam int unsigned APB_PACKET_WIDTH = 84;

  typedef struct packed {
    logic        valid;
    logic        resp;
    logic        write;
    logic        err;
    logic [3:0]  dst_x;
    logic [3:0]  dst_y;
    logic [3:0]  src_x;
    logic [3:0]  src_y;
    logic [31:0] addr;
    logic [31:0] data;
  } pkt_t;
endpackage

module noc_apb_ni #(
  parameter int unsigned GRID_WIDTH     = 4,
  parameter int unsigned NODE_X         = 0,
  parameter int unsigned NODE_Y         = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                i_clk,
  input  logic                i_srst_n,
  noc_apb_ni_if.slave         ini_apb,
  noc_apb_ni_if.master        tgt_apb,
  output logic [83:0]         o_niToRouter,
  input  logic [83:0]         i_routerToNi,
  output logic [7:0]          o_dropCount
);
  import pa_noc::*;

  if (GRID_WIDTH < 2 || GRID_WIDTH > 16) begin : g_bad_grid
    $error("noc_apb_ni: GRID_WIDTH must be within 2..16");
  end
  if (NODE_X >= GRID_WIDTH) begin : g_bad_x
    $error("noc_apb_ni: NODE_X must be below GRID_WIDTH");
  end
  if (NODE_Y >= GRID_WIDTH) begin : g_bad_y
    $error("noc_apb_ni: NODE_Y must be below GRID_WIDTH");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_tmo
    $error("noc_apb_ni: TIMEOUT_CYCLES must be non-zero");
  end
  if (APB_PACKET_WIDTH != 84) begin : g_bad_pkt
    $error("noc_apb_ni: pa_noc::APB_PACKET_WIDTH must be 84");
  end

  localparam logic [3:0] OWN_X = 4'(NODE_X);
  localparam logic [3:0] OWN_Y = 4'(NODE_Y);

  localparam logic [1:0] I_IDLE = 2'd0;
  localparam logic [1:0] I_SEND = 2'd1;
  localparam logic [1:0] I_WAIT = 2'd2;
  localparam logic [1:0] I_DONE = 2'd3;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_SETUP  = 2'd1;
  localparam logic [1:0] T_ACCESS = 2'd2;
  localparam logic [1:0] T_RESP   = 2'd3;

  pkt_t rx;
  pkt_t tx_next;
  assign rx = i_routerToNi;

  // Initiator state
  logic [1:0]  ini_state;
  logic        ini_write;
  logic [31:0] ini_addr;
  logic [31:0] ini_wdata;
  logic [31:0] ini_rdata;
  logic        ini_err;
  logic [31:0] ini_count;

  // Target state
  logic [1:0]  tgt_state;
  logic [3:0]  tgt_src_x;
  logic [3:0]  tgt_src_y;
  logic        tgt_write;
  logic [31:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [31:0] tgt_rdata;
  logic        tgt_err;

  logic [3:0] req_x;
  logic [3:0] req_y;
  logic       req_bad;
  logic       rx_for_me;
  logic       rsp_match;
  logic       tgt_take;
  logic       drop;
  logic       ini_inject;

  assign req_x   = ini_apb.paddr[31:28];
  assign req_y   = ini_apb.paddr[27:24];
  assign req_bad = (32'(req_x) >= GRID_WIDTH) || (32'(req_y) >= GRID_WIDTH) ||
                   (req_x == OWN_X && req_y == OWN_Y);

  assign rx_for_me = rx.valid && rx.dst_x == OWN_X && rx.dst_y == OWN_Y;
  assign rsp_match = rx_for_me && rx.resp && ini_state == I_WAIT &&
                     rx.src_x == ini_addr[31:28] && rx.src_y == ini_addr[27:24] &&
                     rx.addr == {8'h0, ini_addr[23:0]};
  assign tgt_take  = rx_for_me && !rx.resp && tgt_state == T_IDLE;
  // Every valid packet that neither FSM consumes is a discard.
  assign drop      = rx.valid && !rsp_match && !tgt_take;

  // Target responses have priority; a blocked request simply stays in I_SEND.
  always_comb begin
    tx_next    = '0;
    ini_inject = 1'b0;
    if (tgt_state == T_RESP) begin
      tx_next.valid = 1'b1;
      tx_next.resp  = 1'b1;
      tx_next.write = tgt_write;
      tx_next.err   = tgt_err;
      tx_next.dst_x = tgt_src_x;
      tx_next.dst_y = tgt_src_y;
      tx_next.src_x = OWN_X;
      tx_next.src_y = OWN_Y;
      tx_next.addr  = tgt_addr;
      tx_next.data  = tgt_rdata;
    end else if (ini_state == I_SEND) begin
      ini_inject    = 1'b1;
      tx_next.valid = 1'b1;
      tx_next.write = ini_write;
      tx_next.dst_x = ini_addr[31:28];
      tx_next.dst_y = ini_addr[27:24];
      tx_next.src_x = OWN_X;
      tx_next.src_y = OWN_Y;
      tx_next.addr  = {8'h0, ini_addr[23:0]};
      tx_next.data  = ini_write ? ini_wdata : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      ini_state <= I_IDLE;
      ini_write <= 1'b0;
      ini_addr  <= '0;
      ini_wdata <= '0;
      ini_rdata <= '0;
      ini_err   <= 1'b0;
      ini_count <= '0;
    end else begin
      case (ini_state)
        I_IDLE: begin
          if (ini_apb.psel && !ini_apb.penable) begin
            ini_write <= ini_apb.pwrite;
            ini_addr  <= ini_apb.paddr;
            ini_wdata <= ini_apb.pwdata;
            if (req_bad) begin
              ini_err   <= 1'b1;
              ini_rdata <= '0;
              ini_state <= I_DONE;
            end else begin
              ini_state <= I_SEND;
            end
          end
        end
        I_SEND: begin
          if (ini_inject) begin
            ini_count <= '0;
            ini_state <= I_WAIT;
          end
        end
        I_WAIT: begin
          if (rsp_match) begin
            ini_rdata <= rx.data;
            ini_err   <= rx.err;
            ini_state <= I_DONE;
          end else if (ini_count == TIMEOUT_CYCLES - 1) begin
            ini_rdata <= '0;
            ini_err   <= 1'b1;
            ini_state <= I_DONE;
          end else begin
            ini_count <= ini_count + 32'd1;
          end
        end
        default: begin
          ini_rdata <= '0;
          ini_err   <= 1'b0;
          ini_state <= I_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      tgt_state <= T_IDLE;
      tgt_src_x <= '0;
      tgt_src_y <= '0;
      tgt_write <= 1'b0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      tgt_rdata <= '0;
      tgt_err   <= 1'b0;
    end else begin
      case (tgt_state)
        T_IDLE: begin
          if (tgt_take) begin
            tgt_src_x <= rx.src_x;
            tgt_src_y <= rx.src_y;
            tgt_write <= rx.write;
            tgt_addr  <= rx.addr;
            tgt_wdata <= rx.data;
            tgt_state <= T_SETUP;
          end
        end
        T_SETUP: tgt_state <= T_ACCESS;
        T_ACCESS: begin
          if (tgt_apb.pready) begin
            tgt_rdata <= tgt_write ? '0 : tgt_apb.prdata;
            tgt_err   <= tgt_apb.pslverr;
            tgt_state <= T_RESP;
          end
        end
        default: tgt_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      o_niToRouter <= '0;
      o_dropCount  <= '0;
    end else begin
      o_niToRouter <= tx_next;
      if (drop && o_dropCount != 8'hFF) begin
        o_dropCount <= o_dropCount + 8'd1;
      end
    end
  end

  assign ini_apb.pready  = (ini_state == I_DONE);
  assign ini_apb.prdata  = (ini_state == I_DONE) ? ini_rdata : '0;
  assign ini_apb.pslverr = (ini_state == I_DONE) && ini_err;

  assign tgt_apb.psel    = (tgt_state == T_SETUP) || (tgt_state == T_ACCESS);
  assign tgt_apb.penable = (tgt_state == T_ACCESS);
  assign tgt_apb.pwrite  = tgt_write;
  assign tgt_apb.paddr   = {8'h0, tgt_addr[23:0]};
  assign tgt_apb.pwdata  = tgt_wdata;
endmodule

// File: tb/tb_noc_apb_ni.sv
// Bench for noc_apb_ni at node (0,0) of a 4x4 mesh; the bench plays router,
// remote nodes, local APB initiator and local APB peripheral.
module tb_noc_apb_ni;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        srst_n;
  logic [83:0] tx;
  logic [83:0] rx;
  logic [7:0]  drops;

  noc_apb_ni_if ini ();
  noc_apb_ni_if tgt ();

  noc_apb_ni #(
    .GRID_WIDTH(4),
    .NODE_X(0),
    .NODE_Y(0),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk       (clk),
    .i_srst_n    (srst_n),
    .ini_apb     (ini),
    .tgt_apb     (tgt),
    .o_niToRouter(tx),
    .i_routerToNi(rx),
    .o_dropCount (drops)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drops = 0;

  logic [83:0] pkt_q[$];  // expected outgoing packets
  logic [64:0] per_q[$];  // expected {pwrite, paddr, pwdata} on the peripheral bus
  logic [32:0] cpl_q[$];  // expected {prdata, pslverr} on initiator completion

  int          per_lat   = 1;
  logic [31:0] per_rdata = '0;
  logic        per_err   = 1'b0;

  function automatic logic [83:0] mk_pkt(input logic resp, input logic write, input logic err,
                                         input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [3:0] sx, input logic [3:0] sy,
                                         input logic [31:0] addr, input logic [31:0] data);
    return {1'b1, resp, write, err, dx, dy, sx, sy, addr, data};
  endfunction

  // Local peripheral: answers after per_lat wait states
  initial begin
    int ctr;
    ctr = 0;
    tgt.pready = 1'b0; tgt.prdata = '0; tgt.pslverr = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tgt.psel && tgt.penable) begin
        if (ctr >= per_lat) begin
          tgt.pready = 1'b1; tgt.prdata = per_rdata; tgt.pslverr = per_err;
        end else begin
          tgt.pready = 1'b0; ctr++;
        end
      end else begin
        tgt.pready = 1'b0; tgt.prdata = '0; tgt.pslverr = 1'b0; ctr = 0;
      end
    end
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    logic [83:0] ep;
    logic [64:0] eb;
    logic [32:0] ec;
    n_checks++;
    if (tx[83] === 1'b1) begin
      if (pkt_q.size() == 0) begin
        n_fail++; $display("FAIL tx_unexpected got=%h expected=none", tx);
      end else begin
        ep = pkt_q.pop_front();
        if (tx !== ep) begin n_fail++; $display("FAIL tx_packet got=%h expected=%h", tx, ep); end
      end
    end else if (tx !== '0) begin
      n_fail++; $display("FAIL tx_idle got=%h expected=0", tx);
    end
    if (ini.pready === 1'b1) begin
      n_checks++;
      if (cpl_q.size() == 0) begin
        n_fail++; $display("FAIL ini_unexpected_ready got=1 expected=0");
      end else begin
        ec = cpl_q.pop_front();
        if ({ini.prdata, ini.pslverr} !== ec) begin
          n_fail++; $display("FAIL ini_completion got=%h expected=%h", {ini.prdata, ini.pslverr}, ec);
        end
      end
    end else begin
      n_checks++;
      if (ini.prdata !== '0 || ini.pslverr !== 1'b0) begin
        n_fail++; $display("FAIL ini_idle_data got=%h/%b expected=0/0", ini.prdata, ini.pslverr);
      end
    end
    if (tgt.psel === 1'b1 && tgt.penable === 1'b1 && tgt.pready === 1'b1) begin
      n_checks++;
      if (per_q.size() == 0) begin
        n_fail++; $display("FAIL per_unexpected got=%h expected=none", {tgt.pwrite, tgt.paddr, tgt.pwdata});
      end else begin
        eb = per_q.pop_front();
        if ({tgt.pwrite, tgt.paddr, tgt.pwdata} !== eb) begin
          n_fail++; $display("FAIL per_access got=%h expected=%h", {tgt.pwrite, tgt.paddr, tgt.pwdata}, eb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic [83:0] p);
    rx = p;
    tick();
    rx = '0;
  endtask

  task automatic apb_setup(input logic w, input logic [31:0] a, input logic [31:0] d);
    ini.psel = 1'b1; ini.penable = 1'b0; ini.pwrite = w; ini.paddr = a; ini.pwdata = d;
    tick();
    ini.penable = 1'b1;
  endtask

  task automatic apb_wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ini.pready === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_ready_timeout got=0 expected=1", name); end
    tick();
    ini.psel = 1'b0; ini.penable = 1'b0;
  endtask

  task automatic wait_tx(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx[83] === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_no_packet got=0 expected=1", name); end
  endtask

  task automatic test_reset();
    srst_n = 1'b0; rx = '0;
    ini.psel = 1'b0; ini.penable = 1'b0; ini.pwrite = 1'b0; ini.paddr = '0; ini.pwdata = '0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({tx, drops, ini.pready, ini.prdata, ini.pslverr, tgt.psel, tgt.penable, tgt.pwrite,
         tgt.paddr, tgt.pwdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got tx=%h drops=%0d ready=%b psel=%b paddr=%h expected all 0",
               tx, drops, ini.pready, tgt.psel, tgt.paddr);
    end
    srst_n = 1'b1;
    tick();
  endtask

  task automatic test_remote_write();
    tick();
    pkt_q.push_back(mk_pkt(0, 1, 0, 4'd1, 4'd0, 4'd0, 4'd0, 32'h0000_0010, 32'hCAFE_F00D));
    cpl_q.push_back({32'h0, 1'b0});
    apb_setup(1'b1, 32'h1000_0010, 32'hCAFE_F00D);
    wait_tx("remote_write");
    tick();
    send_pkt(mk_pkt(1, 1, 0, 4'd0, 4'd0, 4'd1, 4'd0, 32'h0000_0010, 32'h0));
    apb_wait_ready("remote_write");
  endtask

  task automatic test_remote_read();
    tick();
    pkt_q.push_back(mk_pkt(0, 0, 0, 4'd1, 4'd0, 4'd0, 4'd0, 32'h0000_0044, 32'h0));
    cpl_q.push_back({32'h1234_5678, 1'b0});
    apb_setup(1'b0, 32'h1000_0044, 32'hFFFF_FFFF);
    wait_tx("remote_read");
    tick();
    send_pkt(mk_pkt(1, 0, 0, 4'd0, 4'd0, 4'd1, 4'd0, 32'h0000_0048, 32'hDEAD_0001));
    exp_drops++;
    send_pkt(mk_pkt(1, 0, 0, 4'd0, 4'd0, 4'd2, 4'd0, 32'h0000_0044, 32'hDEAD_0002));
    exp_drops++;
    send_pkt(mk_pkt(1, 0, 0, 4'd0, 4'd0, 4'd1, 4'd0, 32'h0000_0044, 32'h1234_5678));
    apb_wait_ready("remote_read");
    @(negedge clk);
    n_checks++;
    if (drops !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL read_drop_count got=%0d expected=%0d", drops, exp_drops);
    end
  endtask

  task automatic test_local_err();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0000_0000;  // own node
    addrs[1] = 32'h4000_0000;  // dstX == GRID_WIDTH
    addrs[2] = 32'h0400_0000;  // dstY == GRID_WIDTH
    tick();
    for (int i = 0; i < 3; i++) begin
      cpl_q.push_back({32'h0, 1'b1});
      apb_setup(1'b1, addrs[i], 32'h5A5A_5A5A);
      apb_wait_ready("local_err");
    end
  endtask

  task automatic test_target();
    tick();
    per_lat = 1; per_rdata = '0; per_err = 1'b0;
    per_q.push_back({1'b1, 32'h0000_0010, 32'hCAFE_F00D});
    pkt_q.push_back(mk_pkt(1, 1, 0, 4'd2, 4'd3, 4'd0, 4'd0, 32'h0000_0010, 32'h0));
    send_pkt(mk_pkt(0, 1, 0, 4'd0, 4'd0, 4'd2, 4'd3, 32'h0000_0010, 32'hCAFE_F00D));
    send_pkt(mk_pkt(0, 1, 0, 4'd0, 4'd0, 4'd3, 4'd3, 32'h0000_0014, 32'h0));  // target busy
    exp_drops++;
    send_pkt(mk_pkt(0, 1, 0, 4'd1, 4'd1, 4'd3, 4'd3, 32'h0000_0014, 32'h0));  // other node
    exp_drops++;
    wait_tx("target_write");
    tick();
    per_rdata = 32'h1234_5678; per_err = 1'b1;
    per_q.push_back({1'b0, 32'h0000_0020, 32'h0});
    pkt_q.push_back(mk_pkt(1, 0, 1, 4'd1, 4'd0, 4'd0, 4'd0, 32'hAB00_0020, 32'h1234_5678));
    send_pkt(mk_pkt(0, 0, 0, 4'd0, 4'd0, 4'd1, 4'd0, 32'hAB00_0020, 32'h0));
    wait_tx("target_read");
    n_checks++;
    if (drops !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL target_drop_count got=%0d expected=%0d", drops, exp_drops);
    end
  endtask

  task automatic test_timeout();
    int waited;
    tick();
    pkt_q.push_back(mk_pkt(0, 0, 0, 4'd3, 4'd3, 4'd0, 4'd0, 32'h0000_0080, 32'h0));
    cpl_q.push_back({32'h0, 1'b1});
    apb_setup(1'b0, 32'h3300_0080, 32'h0);
    wait_tx("timeout");
    waited = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ini.pready === 1'b1) begin waited = i; break; end
    end
    n_checks++;
    if (waited != TMO) begin
      n_fail++; $display("FAIL timeout_wait_cycles got=%0d expected=%0d", waited, TMO);
    end
    tick();
    ini.psel = 1'b0; ini.penable = 1'b0;
    send_pkt(mk_pkt(1, 0, 0, 4'd0, 4'd0, 4'd3, 4'd3, 32'h0000_0080, 32'hDEAD_BEEF));
    exp_drops++;
    @(negedge clk);
    n_checks++;
    if (drops !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL late_resp_drop got=%0d expected=%0d", drops, exp_drops);
    end
  endtask

  task automatic test_collision();
    logic [83:0] rsp;
    logic [83:0] req;
    tick();
    per_lat = 0; per_rdata = '0; per_err = 1'b0;
    rsp = mk_pkt(1, 1, 0, 4'd1, 4'd2, 4'd0, 4'd0, 32'h0000_0030, 32'h0);
    req = mk_pkt(0, 1, 0, 4'd2, 4'd1, 4'd0, 4'd0, 32'h0000_0034, 32'h0BAD_F00D);
    per_q.push_back({1'b1, 32'h0000_0030, 32'h5555_AAAA});
    pkt_q.push_back(rsp);
    pkt_q.push_back(req);
    send_pkt(mk_pkt(0, 1, 0, 4'd0, 4'd0, 4'd1, 4'd2, 32'h0000_0030, 32'h5555_AAAA));
    tick();
    apb_setup(1'b1, 32'h2100_0034, 32'h0BAD_F00D);
    @(negedge clk);
    n_checks++;
    if (tx !== '0) begin n_fail++; $display("FAIL collision_pre got=%h expected=0", tx); end
    @(negedge clk);
    n_checks++;
    if (tx !== rsp) begin n_fail++; $display("FAIL collision_first got=%h expected=%h", tx, rsp); end
    @(negedge clk);
    n_checks++;
    if (tx !== req) begin n_fail++; $display("FAIL collision_second got=%h expected=%h", tx, req); end
    @(negedge clk);
    n_checks++;
    if (tx !== '0) begin n_fail++; $display("FAIL collision_after got=%h expected=0", tx); end
    tick();
    cpl_q.push_back({32'h0, 1'b0});
    send_pkt(mk_pkt(1, 1, 0, 4'd0, 4'd0, 4'd2, 4'd1, 32'h0000_0034, 32'h0));
    apb_wait_ready("collision");
  endtask

  task automatic test_reset_mid_wait();
    tick();
    pkt_q.push_back(mk_pkt(0, 1, 0, 4'd1, 4'd0, 4'd0, 4'd0, 32'h0000_0050, 32'h1111_2222));
    apb_setup(1'b1, 32'h1000_0050, 32'h1111_2222);
    wait_tx("reset_wait");
    tick();
    srst_n = 1'b0;
    ini.psel = 1'b0; ini.penable = 1'b0;
    tick();
    srst_n = 1'b1;
    exp_drops = 0;
    @(negedge clk);
    n_checks++;
    if ({tx, drops, ini.pready, ini.prdata, ini.pslverr, tgt.psel, tgt.penable, tgt.pwrite,
         tgt.paddr, tgt.pwdata} !== '0) begin
      n_fail++;
      $display("FAIL midwait_reset_outputs got tx=%h drops=%0d ready=%b psel=%b paddr=%h expected all 0",
               tx, drops, ini.pready, tgt.psel, tgt.paddr);
    end
    tick();
    n_checks++;
    if (drops !== 8'd0) begin n_fail++; $display("FAIL midwait_drop_hold got=%0d expected=0", drops); end
    send_pkt(mk_pkt(1, 1, 0, 4'd0, 4'd0, 4'd1, 4'd0, 32'h0000_0050, 32'h0));
    exp_drops++;
    @(negedge clk);
    n_checks++;
    if (drops !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL midwait_resp_dropped got=%0d expected=%0d", drops, exp_drops);
    end
  endtask

  task automatic test_drop_saturate();
    tick();
    rx = mk_pkt(0, 0, 0, 4'd3, 4'd2, 4'd1, 4'd1, 32'h0, 32'h0);
    repeat (253) tick();
    rx = '0;
    exp_drops = (exp_drops + 253 > 255) ? 255 : exp_drops + 253;
    @(negedge clk);
    n_checks++;
    if (drops !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL drop_below_sat got=%0d expected=%0d", drops, exp_drops);
    end
    tick();
    rx = mk_pkt(1, 0, 0, 4'd2, 4'd2, 4'd1, 4'd1, 32'h0, 32'h0);
    repeat (5) tick();
    rx = '0;
    exp_drops = (exp_drops + 5 > 255) ? 255 : exp_drops + 5;
    @(negedge clk);
    n_checks++;
    if (drops !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL drop_saturated got=%0d expected=%0d", drops, exp_drops);
    end
  endtask

  initial begin
    test_reset();
    test_remote_write();
    test_remote_read();
    test_local_err();
    test_target();
    test_timeout();
    test_collision();
    test_reset_mid_wait();
    test_drop_saturate();
    repeat (3) tick();
    n_checks++;
    if (pkt_q.size() != 0 || per_q.size() != 0 || cpl_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got pkt=%0d per=%0d cpl=%0d expected=0/0/0",
               pkt_q.size(), per_q.size(), cpl_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog got=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
